mem_stage_hs: RTL and testbench
===============================

MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 Parameter PC_W, default 32, width of the PC field carried to WB.
REQ-002 Parameter RF_AW, default 5, width of the register-file write address.
REQ-003 Parameter ALE_EN, default 1, enables misaligned-address detection (0: low address bits ignored, access always issued).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 ex_valid / ex_ready  in/out  1/1  EX-to-MEM handshake; transfer occurs when both are high on a rising edge.
REQ-007 ex_pc  in  PC_W  instruction PC.
REQ-008 ex_mem_op  in  4  operation: 0000 none, 0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 1111 LW, 1000 SB, 1001 SH, 1010 SW; other codes are treated as none.
REQ-009 ex_result  in  32  ALU result, or effective address for memory ops.
REQ-010 ex_store_data  in  32  store source value (unshifted).
REQ-011 ex_rf_we / ex_rf_waddr  in  1/RF_AW  destination register control.
REQ-012 flush  in  1  cancels the instruction held in the stage.
REQ-013 data_req, data_wr, data_size[1:0], data_addr[31:0], data_wstrb[3:0], data_wdata[31:0]  out  data-memory request.
REQ-014 data_addr_ok, data_data_ok  in  1  request accept and response strobes; data_rdata  in  32  load data.
REQ-015 wb_valid / wb_ready  out/in  1/1  MEM-to-WB handshake.
REQ-016 wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata, wb_excp_ale  out  PC_W/1/RF_AW/32/1  WB payload.
REQ-017 fw_rf_we, fw_rf_waddr, fw_rf_wdata, fw_pending  out  1/RF_AW/32/1  forwarding to ID.

Function
REQ-018 The stage SHALL implement the states IDLE, ISSUE, WAIT, DONE and DRAIN, and SHALL hold at most one instruction.
REQ-019 ex_ready SHALL equal (IDLE) or (DONE and wb_ready), and SHALL be low while flush is high.
REQ-020 On acceptance of a non-memory op the stage SHALL enter DONE; wb_valid rises on the next cycle and wb_rf_wdata equals ex_result.
REQ-021 On acceptance of a memory op the stage SHALL enter ISSUE and drive data_req=1 with data_addr = {ex_result[31:2], 2'b00}.
REQ-022 data_req SHALL stay high with stable payload until data_addr_ok, then the stage SHALL enter WAIT (data_req low); if data_data_ok arrives in the same cycle as data_addr_ok, the stage SHALL go directly to DONE.
REQ-023 In WAIT, data_data_ok SHALL move the stage to DONE and register the extended load data; stores SHALL also wait for data_data_ok.
REQ-024 data_size: byte 00, half 01, word 10; data_wr=1 for stores.
REQ-025 Store byte strobes: SB gives 0001 shifted left by addr[1:0], SH gives 0011 or 1100 selected by addr[1], SW gives 1111; data_wdata SHALL replicate the byte/half across all lanes; loads SHALL drive wstrb 0000.
REQ-026 Load extension: LB/LBU select byte addr[1:0], sign/zero-extended; LH/LHU select half addr[1], sign/zero-extended; LW passes data_rdata through.
REQ-027 With ALE_EN=1, a half op with addr[0]=1 or a word op with addr[1:0]!=0 SHALL issue no request, go to DONE with wb_excp_ale=1 and wb_rf_we=0.
REQ-028 In DONE, wb_valid SHALL be 1; the stage leaves DONE when wb_ready=1, going to the next accepted instruction's state, or to IDLE if none is accepted.
REQ-029 Flush in IDLE or DONE SHALL go to IDLE with wb_valid=0 in the next cycle.
REQ-030 Flush in ISSUE without data_addr_ok SHALL drop data_req and go to IDLE; flush in ISSUE with data_addr_ok, or in WAIT, SHALL go to DRAIN.
REQ-031 DRAIN SHALL hold ex_ready=0 and discard the first data_data_ok, then go to IDLE; flush has no further effect in DRAIN.
REQ-032 fw_pending SHALL be 1 in ISSUE or WAIT for a load with rf_we=1.
REQ-033 fw_rf_we SHALL equal wb_valid and wb_rf_we; fw_rf_waddr and fw_rf_wdata SHALL mirror the WB payload.

Reset
REQ-034 resetn=0 SHALL immediately force IDLE, and drive ex_ready=1 and all other outputs to 0, independent of clk.
REQ-035 A reset during ISSUE, WAIT or DRAIN SHALL abandon the transaction; the memory side is reset by the same resetn.

Verification
REQ-036 ALU op with ex_result=0x1234, rf_waddr=3 accepted at cycle N -> wb_valid=1 at N+1 with wdata 0x1234, fw_rf_we=1.
REQ-037 LB at address 0x103, data_addr_ok at N+1, data_data_ok at N+3 with rdata 0x80FF_0000 -> data_addr 0x100, size 00, wb_rf_wdata 0xFFFF_FF80 at N+4; fw_pending high N+1..N+3.
REQ-038 SH at address 0x22, store_data 0x0000_ABCD -> wstrb 1100, wdata 0xABCD_ABCD, wr=1.
REQ-039 LW at address 0x06 with ALE_EN=1 -> no data_req, wb_excp_ale=1, wb_rf_we=0 at N+1.
REQ-040 Flush in WAIT, then data_data_ok 2 cycles later -> DRAIN, no wb_valid, ex_ready=0 until the cycle after data_data_ok.
REQ-041 wb_ready=0 for 3 cycles in DONE -> wb payload stable, ex_ready=0; resetn pulse mid-WAIT -> IDLE and all outputs at reset values immediately.

Source files
------------

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: issues one data-memory request per load/store over a
// valid/ready handshake, extends load data, and presents the result to WB.
module mem_stage_hs #(
  parameter int PC_W   = 32,
  parameter int RF_AW  = 5,
  parameter int ALE_EN = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [3:0]       ex_mem_op,
  input  logic [31:0]      ex_result,
  input  logic [31:0]      ex_store_data,
  input  logic             ex_rf_we,
  input  logic [RF_AW-1:0] ex_rf_waddr,
  input  logic             flush,
  output logic             data_req,
  output logic             data_wr,
  output logic [1:0]       data_size,
  output logic [31:0]      data_addr,
  output logic [3:0]       data_wstrb,
  output logic [31:0]      data_wdata,
  input  logic             data_addr_ok,
  input  logic             data_data_ok,
  input  logic [31:0]      data_rdata,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [PC_W-1:0]  wb_pc,
  output logic             wb_rf_we,
  output logic [RF_AW-1:0] wb_rf_waddr,
  output logic [31:0]      wb_rf_wdata,
  output logic             wb_excp_ale,
  output logic             fw_rf_we,
  output logic [RF_AW-1:0] fw_rf_waddr,
  output logic [31:0]      fw_rf_wdata,
  output logic             fw_pending
);

  localparam logic [3:0] OP_NONE = 4'b0000, OP_LB = 4'b0001, OP_LBU = 4'b0010,
                         OP_LH   = 4'b0011, OP_LHU = 4'b0100, OP_LW = 4'b1111,
                         OP_SB   = 4'b1000, OP_SH = 4'b1001, OP_SW = 4'b1010;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_p1;
  logic [3:0]        op_p1;
  logic [31:0]       addr_p1;
  logic [31:0]       sdata_p1;
  logic              rf_we_p1;
  logic [RF_AW-1:0]  rf_waddr_p1;
  logic [31:0]       wdata_p1;
  logic              excp_p1;

  logic [3:0] op_n;
  logic       mis_n;
  logic       accept;
  logic       load_cap;
  state_t     acc_state;

  function automatic logic [3:0] norm_op(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: norm_op = op;
      default: norm_op = OP_NONE;
    endcase
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    is_load = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
              (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: op_size = 2'b01;
      OP_LW, OP_SW:         op_size = 2'b10;
      default:              op_size = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_SB:   store_strb = 4'b0001 << a;
      OP_SH:   store_strb = a[1] ? 4'b1100 : 4'b0011;
      OP_SW:   store_strb = 4'b1111;
      default: store_strb = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   store_lanes = {4{d[7:0]}};
      OP_SH:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] r_s;
    b_s = rd[8*a +: 8];
    h_s = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   r_s = b_s;
      OP_LBU:  r_s = {24'd0, b_s};
      OP_LH:   r_s = h_s;
      OP_LHU:  r_s = {16'd0, h_s};
      default: r_s = rd;
    endcase
    load_ext = r_s;
  endfunction

  assign op_n  = norm_op(ex_mem_op);
  assign mis_n = (ALE_EN != 0) &&
                 ((op_size(op_n) == 2'b01 && ex_result[0]) ||
                  (op_size(op_n) == 2'b10 && ex_result[1:0] != 2'b00));
  assign accept    = ex_valid && ex_ready;
  assign acc_state = (op_n != OP_NONE && !mis_n) ? ISSUE : DONE;
  assign load_cap  = (state_q == ISSUE || state_q == WAIT) && state_d == DONE && is_load(op_p1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A flush racing a response completes the drain in the same cycle, avoiding a DRAIN
  // that would wait for a second response which never arrives.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = acc_state;
      ISSUE: if (flush) state_d = (data_addr_ok && !data_data_ok) ? DRAIN : IDLE;
             else if (data_addr_ok) state_d = data_data_ok ? DONE : WAIT;
      WAIT:  if (flush) state_d = data_data_ok ? IDLE : DRAIN;
             else if (data_data_ok) state_d = DONE;
      DRAIN: if (data_data_ok) state_d = IDLE;
      DONE:  if (flush) state_d = IDLE;
             else if (wb_ready) state_d = accept ? acc_state : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ex_ready   = !flush && (state_q == IDLE || (state_q == DONE && wb_ready));
    data_req   = (state_q == ISSUE);
    wb_valid   = (state_q == DONE);
    fw_pending = (state_q == ISSUE || state_q == WAIT) && is_load(op_p1) && rf_we_p1;
  end

  // Held instruction; cleared by reset so every payload output reads zero in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_p1       <= '0;
      op_p1       <= OP_NONE;
      addr_p1     <= '0;
      sdata_p1    <= '0;
      rf_we_p1    <= 1'b0;
      rf_waddr_p1 <= '0;
      wdata_p1    <= '0;
      excp_p1     <= 1'b0;
    end else if (accept) begin
      pc_p1       <= ex_pc;
      op_p1       <= op_n;
      addr_p1     <= ex_result;
      sdata_p1    <= ex_store_data;
      rf_we_p1    <= ex_rf_we && !mis_n;
      rf_waddr_p1 <= ex_rf_waddr;
      wdata_p1    <= ex_result;
      excp_p1     <= mis_n;
    end else if (load_cap) begin
      wdata_p1    <= load_ext(op_p1, addr_p1[1:0], data_rdata);
    end
  end

  assign data_wr     = data_req && !is_load(op_p1);
  assign data_size   = data_req ? op_size(op_p1) : 2'b00;
  assign data_addr   = data_req ? {addr_p1[31:2], 2'b00} : 32'd0;
  assign data_wstrb  = data_req ? store_strb(op_p1, addr_p1[1:0]) : 4'b0000;
  assign data_wdata  = data_req ? store_lanes(op_p1, sdata_p1) : 32'd0;

  assign wb_pc       = pc_p1;
  assign wb_rf_we    = rf_we_p1;
  assign wb_rf_waddr = rf_waddr_p1;
  assign wb_rf_wdata = wdata_p1;
  assign wb_excp_ale = excp_p1;

  assign fw_rf_we    = wb_valid && rf_we_p1;
  assign fw_rf_waddr = rf_waddr_p1;
  assign fw_rf_wdata = wdata_p1;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: handshake, load/store formatting, misalignment,
// flush/drain, back-pressure and asynchronous reset.
module tb_mem_stage_hs;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        ex_valid = 1'b0, ex_rf_we = 1'b0, flush = 1'b0, wb_ready = 1'b1;
  logic        ex_ready;
  logic [31:0] ex_pc = '0, ex_result = '0, ex_store_data = '0, data_rdata = '0;
  logic [3:0]  ex_mem_op = '0;
  logic [4:0]  ex_rf_waddr = '0;
  logic        data_req, data_wr, data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        wb_valid, wb_rf_we, wb_excp_ale, fw_rf_we, fw_pending;
  logic [31:0] wb_pc, wb_rf_wdata, fw_rf_wdata;
  logic [4:0]  wb_rf_waddr, fw_rf_waddr;
  int n_chk = 0;
  int n_fail = 0;

  mem_stage_hs dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_mem_op(ex_mem_op), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
    .wb_rf_wdata(wb_rf_wdata), .wb_excp_ale(wb_excp_ale), .fw_rf_we(fw_rf_we),
    .fw_rf_waddr(fw_rf_waddr), .fw_rf_wdata(fw_rf_wdata), .fw_pending(fw_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] res, input logic [31:0] sd,
                         input logic we, input logic [4:0] wa, input logic [31:0] pc);
    ex_valid = 1'b1; ex_mem_op = op; ex_result = res; ex_store_data = sd;
    ex_rf_we = we; ex_rf_waddr = wa; ex_pc = pc;
  endtask

  task automatic test_reset;
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ex_ready got=%0h exp=1", ex_ready); end
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid got=%0h exp=0", wb_valid); end
    n_chk++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL rst_data_req got=%0h exp=0", data_req); end
    n_chk++; if ({fw_pending, fw_rf_we} !== 2'b00) begin n_fail++; $display("FAIL rst_fw got=%0h exp=0", {fw_pending, fw_rf_we}); end
    n_chk++; if (wb_pc !== 32'd0) begin n_fail++; $display("FAIL rst_wb_pc got=%0h exp=0", wb_pc); end
    resetn = 1'b1;
    tick;
  endtask

  task automatic test_alu;
    wb_ready = 1'b1;
    present(4'b0000, 32'h1234, 32'h0, 1'b1, 5'd3, 32'h1000);
    #1;
    n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ex_ready got=%0h exp=1", ex_ready); end
    tick; ex_valid = 1'b0; #1;
    n_chk++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_wb_valid got=%0h exp=1", wb_valid); end
    n_chk++; if (wb_rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL alu_wdata got=%0h exp=1234", wb_rf_wdata); end
    n_chk++; if (fw_rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_fw_we got=%0h exp=1", fw_rf_we); end
    n_chk++; if (fw_rf_waddr !== 5'd3) begin n_fail++; $display("FAIL alu_fw_waddr got=%0h exp=3", fw_rf_waddr); end
    n_chk++; if (wb_pc !== 32'h1000) begin n_fail++; $display("FAIL alu_wb_pc got=%0h exp=1000", wb_pc); end
    n_chk++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL alu_no_req got=%0h exp=0", data_req); end
    tick;
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_wb_clear got=%0h exp=0", wb_valid); end
  endtask

  task automatic test_flush_ready;
    flush = 1'b1; #1;
    n_chk++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ex_ready got=%0h exp=0", ex_ready); end
    flush = 1'b0; #1;
  endtask

  task automatic test_lb;
    present(4'b0001, 32'h103, 32'h0, 1'b1, 5'd5, 32'h2000);
    tick; ex_valid = 1'b0; #1;
    n_chk++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL lb_req got=%0h exp=1", data_req); end
    n_chk++; if (data_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr got=%0h exp=100", data_addr); end
    n_chk++; if ({data_size, data_wr, data_wstrb} !== 7'd0) begin n_fail++; $display("FAIL lb_ctl got=%0h exp=0", {data_size, data_wr, data_wstrb}); end
    n_chk++; if (fw_pending !== 1'b1) begin n_fail++; $display("FAIL lb_pend_issue got=%0h exp=1", fw_pending); end
    data_addr_ok = 1'b1;
    tick; data_addr_ok = 1'b0; #1;
    n_chk++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL lb_req_drop got=%0h exp=0", data_req); end
    n_chk++; if (fw_pending !== 1'b1) begin n_fail++; $display("FAIL lb_pend_wait got=%0h exp=1", fw_pending); end
    tick;
    n_chk++; if ({fw_pending, wb_valid} !== 2'b10) begin n_fail++; $display("FAIL lb_still_wait got=%0h exp=2", {fw_pending, wb_valid}); end
    data_data_ok = 1'b1; data_rdata = 32'h80FF_0000;
    tick; data_data_ok = 1'b0; #1;
    n_chk++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL lb_wb_valid got=%0h exp=1", wb_valid); end
    n_chk++; if (wb_rf_wdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_wdata got=%0h exp=ffffff80", wb_rf_wdata); end
    n_chk++; if (fw_pending !== 1'b0) begin n_fail++; $display("FAIL lb_pend_done got=%0h exp=0", fw_pending); end
    tick;
  endtask

  task automatic test_lhu;
    present(4'b0100, 32'h2, 32'h0, 1'b1, 5'd7, 32'h2004);
    tick; ex_valid = 1'b0; #1;
    n_chk++; if (data_size !== 2'b01) begin n_fail++; $display("FAIL lhu_size got=%0h exp=1", data_size); end
    data_addr_ok = 1'b1;
    tick; data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h8001_0000;
    tick; data_data_ok = 1'b0; #1;
    n_chk++; if (wb_rf_wdata !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_wdata got=%0h exp=8001", wb_rf_wdata); end
    tick;
  endtask

  task automatic test_sh;
    present(4'b1001, 32'h22, 32'h0000_ABCD, 1'b0, 5'd0, 32'h2008);
    tick; ex_valid = 1'b0; #1;
    n_chk++; if (data_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sh_wstrb got=%0h exp=c", data_wstrb); end
    n_chk++; if (data_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata got=%0h exp=abcdabcd", data_wdata); end
    n_chk++; if ({data_wr, data_size} !== 3'b101) begin n_fail++; $display("FAIL sh_wr_size got=%0h exp=5", {data_wr, data_size}); end
    n_chk++; if (data_addr !== 32'h20) begin n_fail++; $display("FAIL sh_addr got=%0h exp=20", data_addr); end
    data_addr_ok = 1'b1; data_data_ok = 1'b1;
    tick; data_addr_ok = 1'b0; data_data_ok = 1'b0; #1;
    n_chk++; if ({wb_valid, data_req, wb_rf_we} !== 3'b100) begin n_fail++; $display("FAIL sh_direct_done got=%0h exp=4", {wb_valid, data_req, wb_rf_we}); end
    tick;
  endtask

  task automatic test_sb;
    present(4'b1000, 32'h41, 32'h1234_565A, 1'b0, 5'd0, 32'h200C);
    tick; ex_valid = 1'b0; #1;
    n_chk++; if (data_wstrb !== 4'b0010) begin n_fail++; $display("FAIL sb_wstrb got=%0h exp=2", data_wstrb); end
    n_chk++; if (data_wdata !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL sb_wdata got=%0h exp=5a5a5a5a", data_wdata); end
    data_addr_ok = 1'b1;
    tick; data_addr_ok = 1'b0; #1;
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL sb_waits_data got=%0h exp=0", wb_valid); end
    data_data_ok = 1'b1;
    tick; data_data_ok = 1'b0; #1;
    n_chk++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL sb_done got=%0h exp=1", wb_valid); end
    tick;
  endtask

  task automatic test_ale;
    present(4'b1111, 32'h6, 32'h0, 1'b1, 5'd9, 32'h2010);
    tick; ex_valid = 1'b0; #1;
    n_chk++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL ale_no_req got=%0h exp=0", data_req); end
    n_chk++; if ({wb_valid, wb_excp_ale} !== 2'b11) begin n_fail++; $display("FAIL ale_excp got=%0h exp=3", {wb_valid, wb_excp_ale}); end
    n_chk++; if ({wb_rf_we, fw_rf_we} !== 2'b00) begin n_fail++; $display("FAIL ale_rf_we got=%0h exp=0", {wb_rf_we, fw_rf_we}); end
    tick;
  endtask

  task automatic test_flush_issue;
    present(4'b1111, 32'h10, 32'h0, 1'b1, 5'd2, 32'h2014);
    tick; ex_valid = 1'b0; flush = 1'b1;
    tick; flush = 1'b0; #1;
    n_chk++; if ({data_req, wb_valid, ex_ready} !== 3'b001) begin n_fail++; $display("FAIL flush_issue got=%0h exp=1", {data_req, wb_valid, ex_ready}); end
  endtask

  task automatic test_flush_wait;
    present(4'b1111, 32'h40, 32'h0, 1'b1, 5'd4, 32'h2018);
    tick; ex_valid = 1'b0; data_addr_ok = 1'b1;
    tick; data_addr_ok = 1'b0; flush = 1'b1;
    tick; flush = 1'b0; #1;
    n_chk++; if ({ex_ready, wb_valid, data_req} !== 3'b000) begin n_fail++; $display("FAIL drain_enter got=%0h exp=0", {ex_ready, wb_valid, data_req}); end
    tick;
    n_chk++; if ({ex_ready, wb_valid} !== 2'b00) begin n_fail++; $display("FAIL drain_hold got=%0h exp=0", {ex_ready, wb_valid}); end
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; #1;
    n_chk++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL drain_rsp_cycle got=%0h exp=0", ex_ready); end
    tick; data_data_ok = 1'b0; #1;
    n_chk++; if ({ex_ready, wb_valid} !== 2'b10) begin n_fail++; $display("FAIL drain_exit got=%0h exp=2", {ex_ready, wb_valid}); end
  endtask

  task automatic test_back_to_back;
    wb_ready = 1'b0;
    present(4'b0000, 32'hAAAA_0001, 32'h0, 1'b1, 5'd4, 32'h3000);
    tick;
    present(4'b0000, 32'h5555_0002, 32'h0, 1'b1, 5'd6, 32'h3004);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if ({wb_valid, ex_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_hs[%0d] got=%0h exp=2", i, {wb_valid, ex_ready}); end
      n_chk++; if (wb_rf_wdata !== 32'hAAAA_0001) begin n_fail++; $display("FAIL bp_wdata[%0d] got=%0h exp=aaaa0001", i, wb_rf_wdata); end
      tick;
    end
    wb_ready = 1'b1; #1;
    n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%0h exp=1", ex_ready); end
    tick; ex_valid = 1'b0; #1;
    n_chk++; if ({wb_valid, wb_rf_wdata} !== {1'b1, 32'h5555_0002}) begin n_fail++; $display("FAIL b2b_wdata got=%0h exp=155550002", {wb_valid, wb_rf_wdata}); end
    n_chk++; if ({wb_pc, wb_rf_waddr} !== {32'h3004, 5'd6}) begin n_fail++; $display("FAIL b2b_pc_waddr got=%0h exp=%0h", {wb_pc, wb_rf_waddr}, {32'h3004, 5'd6}); end
    tick;
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%0h exp=0", wb_valid); end
  endtask

  task automatic test_reset_mid_wait;
    present(4'b1111, 32'h80, 32'h0, 1'b1, 5'd8, 32'h4000);
    tick; ex_valid = 1'b0; data_addr_ok = 1'b1;
    tick; data_addr_ok = 1'b0; #1;
    n_chk++; if (fw_pending !== 1'b1) begin n_fail++; $display("FAIL rw_pending got=%0h exp=1", fw_pending); end
    #2 resetn = 1'b0;
    #1;
    n_chk++; if ({ex_ready, fw_pending, data_req, wb_valid} !== 4'b1000) begin n_fail++; $display("FAIL rw_ctl got=%0h exp=8", {ex_ready, fw_pending, data_req, wb_valid}); end
    n_chk++; if ({wb_pc, wb_rf_wdata, wb_rf_waddr} !== '0) begin n_fail++; $display("FAIL rw_payload got=%0h exp=0", {wb_pc, wb_rf_wdata, wb_rf_waddr}); end
    #3 resetn = 1'b1;
    tick;
    n_chk++; if ({ex_ready, wb_valid} !== 2'b10) begin n_fail++; $display("FAIL rw_after got=%0h exp=2", {ex_ready, wb_valid}); end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_flush_ready;
    test_lb;
    test_lhu;
    test_sh;
    test_sb;
    test_ale;
    test_flush_issue;
    test_flush_wait;
    test_back_to_back;
    test_reset_mid_wait;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
